// File: rtl/jtag_lock_ctrl_if.sv
// rtl/jtag_lock_ctrl_if.sv - key-unlock handshake bundle for jtag_lock_ctrl
interface jtag_lock_ctrl_if #(
  parameter int NUM_CH = 4,
  parameter int KEY_W  = 32
);
  logic [KEY_W-1:0]  key_in;
  logic              key_valid;
  logic [NUM_CH-1:0] unlock_mask;
  logic              key_ready;
  logic              key_ack;
  logic              key_pass;
  logic [3:0]        tries_left;

  modport master (
    output key_in, key_valid, unlock_mask,
    input  key_ready, key_ack, key_pass, tries_left
  );

  modport slave (
    input  key_in, key_valid, unlock_mask,
    output key_ready, key_ack, key_pass, tries_left
  );
endinterface

// File: rtl/jtag_lock_ctrl.sv
// rtl/jtag_lock_ctrl.sv - sticky per-channel JTAG locks, key unlock under JTAG_LOCK_UNLOCK_KEY_EN
module jtag_lock_ctrl #(
  parameter int                NUM_CH       = 4,
  parameter int                KEY_W        = 32,
  parameter int                MAX_TRIES    = 3,
  parameter logic [NUM_CH-1:0] LOCK_RST_VAL = {NUM_CH{1'b1}}
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_CH-1:0]   d,
  input  logic                en,
  input  logic [KEY_W-1:0]    key_ref,
  jtag_lock_ctrl_if.slave     kif,
  output logic                lockout,
  output logic [NUM_CH-1:0]   lock_jtag
);

  localparam logic [3:0] TRIES_INIT = 4'(MAX_TRIES);

`ifdef JTAG_LOCK_UNLOCK_KEY_EN

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_RESULT, S_LOCKOUT} state_t;

  state_t            state_q, state_d;
  logic [KEY_W-1:0]  key_q;
  logic [NUM_CH-1:0] mask_q;
  logic              match_q;
  logic [3:0]        tries_q, tries_d;
  logic              lockout_q, lockout_d;
  logic [NUM_CH-1:0] lock_q, lock_d;
  logic              capture;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    capture       = 1'b0;
    kif.key_ready = 1'b0;
    kif.key_ack   = 1'b0;
    kif.key_pass  = 1'b0;
    tries_d       = tries_q;
    lockout_d     = lockout_q;
    lock_d        = lock_q;
    case (state_q)
      S_IDLE: begin
        kif.key_ready = 1'b1;
        if (kif.key_valid) begin
          capture = 1'b1;
          state_d = S_CHECK;
        end
      end
      S_CHECK: state_d = S_RESULT;
      S_RESULT: begin
        kif.key_ack  = 1'b1;
        kif.key_pass = match_q;
        if (match_q) begin
          lock_d  = lock_q & ~mask_q;
          tries_d = TRIES_INIT;
          state_d = S_IDLE;
        end else begin
          tries_d = (tries_q == 4'd0) ? 4'd0 : tries_q - 4'd1;
          if (tries_q <= 4'd1) begin
            lockout_d = 1'b1;
            state_d   = S_LOCKOUT;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_LOCKOUT: state_d = S_LOCKOUT;
      default:   state_d = S_IDLE;
    endcase
    // Set after release so a same-cycle lock request wins per bit; lockout overrides all.
    if (en)        lock_d = lock_d | d;
    if (lockout_d) lock_d = '1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_q     <= '0;
      mask_q    <= '0;
      match_q   <= 1'b0;
      tries_q   <= TRIES_INIT;
      lockout_q <= 1'b0;
      lock_q    <= LOCK_RST_VAL;
    end else begin
      if (capture) begin
        key_q  <= kif.key_in;
        mask_q <= kif.unlock_mask;
      end
      if (state_q == S_CHECK) match_q <= (key_q == key_ref);
      tries_q   <= tries_d;
      lockout_q <= lockout_d;
      lock_q    <= lock_d;
    end
  end

  assign kif.tries_left = tries_q;
  assign lockout        = lockout_q;
  assign lock_jtag      = lock_q;

`else

  logic [NUM_CH-1:0] lock_q;
  logic              unused_key_inputs;

  always_ff @(posedge clk) begin
    if (rst)     lock_q <= LOCK_RST_VAL;
    else if (en) lock_q <= lock_q | d;
  end

  assign unused_key_inputs = ^{kif.key_in, kif.key_valid, kif.unlock_mask, key_ref};

  assign kif.key_ready  = 1'b0;
  assign kif.key_ack    = 1'b0;
  assign kif.key_pass   = 1'b0;
  assign kif.tries_left = TRIES_INIT;
  assign lockout        = 1'b0;
  assign lock_jtag      = lock_q;

`endif

endmodule

// File: tb/tb_jtag_lock_ctrl.sv
// tb/tb_jtag_lock_ctrl.sv - directed and random checks of jtag_lock_ctrl against a transaction model
module tb_jtag_lock_ctrl;
  localparam int NUM_CH    = 4;
  localparam int KEY_W     = 32;
  localparam int MAX_TRIES = 3;
  localparam logic [31:0] REF_KEY = 32'hA5A5_5A5A;
`ifdef JTAG_LOCK_UNLOCK_KEY_EN
  localparam bit KEY_EN = 1'b1;
`else
  localparam bit KEY_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NUM_CH-1:0] d = '0;
  logic              en = 1'b0;
  logic [KEY_W-1:0]  key_ref = REF_KEY;
  logic              lockout_a, lockout_b;
  logic [NUM_CH-1:0] lock_a, lock_b;

  jtag_lock_ctrl_if #(.NUM_CH(NUM_CH), .KEY_W(KEY_W)) if_a ();
  jtag_lock_ctrl_if #(.NUM_CH(NUM_CH), .KEY_W(KEY_W)) if_b ();

  assign if_b.key_in      = if_a.key_in;
  assign if_b.key_valid   = if_a.key_valid;
  assign if_b.unlock_mask = if_a.unlock_mask;

  jtag_lock_ctrl #(.NUM_CH(NUM_CH), .KEY_W(KEY_W), .MAX_TRIES(MAX_TRIES)) dut_a (
    .clk(clk), .rst(rst), .d(d), .en(en), .key_ref(key_ref),
    .kif(if_a.slave), .lockout(lockout_a), .lock_jtag(lock_a)
  );

  jtag_lock_ctrl #(.NUM_CH(NUM_CH), .KEY_W(KEY_W), .MAX_TRIES(MAX_TRIES),
                   .LOCK_RST_VAL(4'b0000)) dut_b (
    .clk(clk), .rst(rst), .d(d), .en(en), .key_ref(key_ref),
    .kif(if_b.slave), .lockout(lockout_b), .lock_jtag(lock_b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: lock vectors of both instances, shared attempt counter and lockout flag.
  logic [NUM_CH-1:0] m_lock_a, m_lock_b;
  int                m_tries;
  bit                m_lockout;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".lock_a"}, 32'(lock_a), 32'(m_lock_a));
    check({tag, ".lock_b"}, 32'(lock_b), 32'(m_lock_b));
    check({tag, ".tries_a"}, 32'(if_a.tries_left), 32'(m_tries));
    check({tag, ".tries_b"}, 32'(if_b.tries_left), 32'(m_tries));
    check({tag, ".lockout_a"}, 32'(lockout_a), 32'(m_lockout));
    check({tag, ".lockout_b"}, 32'(lockout_b), 32'(m_lockout));
    check({tag, ".ready"}, 32'(if_a.key_ready), 32'(KEY_EN && !m_lockout));
    check({tag, ".ack"}, 32'(if_a.key_ack), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_lock_a  = '1;
    m_lock_b  = '0;
    m_tries   = KEY_EN ? MAX_TRIES : MAX_TRIES;
    m_lockout = 1'b0;
    check_idle("reset");
  endtask

  task automatic apply_set(input bit e, input logic [NUM_CH-1:0] dv);
    if (e && !m_lockout) begin
      m_lock_a = m_lock_a | dv;
      m_lock_b = m_lock_b | dv;
    end
  endtask

  task automatic set_locks(input bit e, input logic [NUM_CH-1:0] dv);
    en = e;
    d  = dv;
    tick();
    en = 1'b0;
    d  = '0;
    apply_set(e, dv);
    check_idle("set");
  endtask

  task automatic attempt(input logic [KEY_W-1:0] key, input logic [NUM_CH-1:0] mask,
                         input bit col_en, input logic [NUM_CH-1:0] col_d, input bit hold);
    bit exp_ack, exp_pass;
    exp_ack  = KEY_EN && !m_lockout;
    exp_pass = exp_ack && (key == REF_KEY);
    if_a.key_in      = key;
    if_a.unlock_mask = mask;
    if_a.key_valid   = 1'b1;
    tick();
    // A key still presented outside IDLE must be dropped, not queued.
    if_a.key_valid   = hold;
    if_a.key_in      = ~key;
    if_a.unlock_mask = ~mask;
    check("att.n1_ack", 32'(if_a.key_ack), 32'd0);
    check("att.n1_ready", 32'(if_a.key_ready), 32'd0);
    tick();
    check("att.ack_a", 32'(if_a.key_ack), 32'(exp_ack));
    check("att.ack_b", 32'(if_b.key_ack), 32'(exp_ack));
    check("att.pass", 32'(if_a.key_pass), 32'(exp_pass));
    en = col_en;
    d  = col_d;
    tick();
    en = 1'b0;
    d  = '0;
    if_a.key_valid = 1'b0;
    if (exp_pass) begin
      m_lock_a = m_lock_a & ~mask;
      m_lock_b = m_lock_b & ~mask;
      m_tries  = MAX_TRIES;
    end else if (exp_ack) begin
      m_tries = (m_tries > 0) ? m_tries - 1 : 0;
      if (m_tries == 0) m_lockout = 1'b1;
    end
    apply_set(col_en, col_d);
    if (m_lockout) begin
      m_lock_a = '1;
      m_lock_b = '1;
    end
    check_idle("att.done");
    tick();
    check("att.n4_ack", 32'(if_a.key_ack), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    if_a.key_in      = '0;
    if_a.key_valid   = 1'b0;
    if_a.unlock_mask = '0;

    do_reset();

    set_locks(1'b1, 4'b0101);
    set_locks(1'b1, 4'b0000);
    set_locks(1'b0, 4'b1010);

    do_reset();
    attempt(REF_KEY, 4'b0011, 1'b0, 4'b0000, 1'b0);

    do_reset();
    attempt(REF_KEY, 4'b1111, 1'b1, 4'b1000, 1'b0);

    do_reset();
    attempt(32'h0, 4'b1111, 1'b0, 4'b0000, 1'b1);
    attempt(REF_KEY, 4'b0000, 1'b0, 4'b0000, 1'b0);

    do_reset();
    attempt(32'h0, 4'b1111, 1'b0, 4'b0000, 1'b0);
    attempt(32'h0, 4'b1111, 1'b0, 4'b0000, 1'b0);
    attempt(32'h0, 4'b1111, 1'b0, 4'b0000, 1'b0);
    attempt(REF_KEY, 4'b1111, 1'b0, 4'b0000, 1'b0);
    set_locks(1'b1, 4'b0000);
    do_reset();

    for (int i = 0; i < 60; i++) begin
      int unsigned op;
      logic [KEY_W-1:0] k;
      op = $urandom_range(0, 15);
      if (op == 0) begin
        do_reset();
      end else if (op < 6) begin
        set_locks(1'($urandom), 4'($urandom));
      end else begin
        k = ($urandom_range(0, 1) == 1) ? REF_KEY : 32'($urandom);
        attempt(k, 4'($urandom), 1'($urandom), 4'($urandom), 1'($urandom));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/jtag_lock_ctrl.md
Name: jtag_lock_ctrl

Overview:
Parametrised successor to the single-bit JTAG lock register. Holds NUM_CH sticky debug-lock bits, each with a defined secure reset value. Supports an optional key-based unlock sequence with an attempt counter and a permanent lockout. Sits between the debug port and the TAP/debug-bus gating logic; each lock_jtag[i] gates one debug channel.

Parameters:
NUM_CH, 4, number of independent lock channels (1..32)
KEY_W, 32, unlock key width in bits
MAX_TRIES, 3, failed key attempts allowed before lockout (1..15)
LOCK_RST_VAL, {NUM_CH{1'b1}}, lock vector loaded on reset; default is all channels locked

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  synchronous, active-high reset
d  in  NUM_CH  per-channel lock request
en  in  1  lock-write enable; qualifies d
key_in  in  KEY_W  candidate unlock key
key_valid  in  1  key_in valid; accepted only when key_ready=1
key_ref  in  KEY_W  reference key from fuse/OTP, static after reset
unlock_mask  in  NUM_CH  channels to release on a successful key; sampled together with key_in
key_ready  out  1  high in IDLE only
key_ack  out  1  one-cycle pulse when an attempt completes
key_pass  out  1  valid with key_ack; 1 = key matched
tries_left  out  4  remaining attempts
lockout  out  1  sticky; all channels locked, no further attempts
lock_jtag  out  NUM_CH  channel lock state; 1 = debug blocked

Behaviour:
- Reset (rst=1 at posedge): lock_jtag=LOCK_RST_VAL, tries_left=MAX_TRIES, lockout=0, key_ack=0, key_pass=0, FSM=IDLE, captured key/mask cleared. Reset mid-attempt aborts the attempt with no ack.
- Lock set: when en=1, lock_jtag[i] <= lock_jtag[i] | d[i] at the next posedge. d=0 never clears a bit. en=0 leaves locks unchanged.
- Locks are never uninitialised. No X after the first reset edge.
- FSM states: IDLE, CHECK, RESULT, LOCKOUT.
- IDLE: key_ready=1. key_valid=1 captures key_in and unlock_mask, then -> CHECK.
- CHECK: compares the captured key with key_ref over the full KEY_W width. -> RESULT.
- RESULT, match: lock_jtag &= ~mask; tries_left=MAX_TRIES; key_ack=1, key_pass=1; -> IDLE.
- RESULT, mismatch: tries_left decrements; key_ack=1, key_pass=0. If the new tries_left is 0: lockout=1, -> LOCKOUT. Otherwise -> IDLE.
- Latency: key_valid at cycle N gives key_ack at cycle N+2. The earliest next accept is cycle N+3.
- LOCKOUT: terminal until rst. lock_jtag forced all-ones. key_ready=0. key_valid ignored. en/d have no visible effect.
- Simultaneous lock-set and unlock in the same RESULT cycle: set wins per bit, i.e. lock_next = (lock & ~mask) | (en ? d : 0).
- key_valid outside IDLE is ignored, not queued.
- tries_left saturates at 0 and never wraps.
- unlock_mask=0 with a correct key: ack with key_pass=1, tries reset, no lock change.

Optional Feature:
Macro JTAG_LOCK_UNLOCK_KEY_EN.
- Defined: key FSM, attempt counter and lockout as above.
- Undefined: no FSM or comparator. key_ready=0, key_ack=0, key_pass=0, lockout=0, tries_left=MAX_TRIES constant. key_in/key_valid/key_ref/unlock_mask are ignored. Locks clear only via rst.

Test Plan:
- Reset value: assert rst one cycle, NUM_CH=4 -> lock_jtag=4'b1111, tries_left=3, lockout=0, key_ready=1.
- Lock set: LOCK_RST_VAL=0, en=1, d=4'b0101 -> lock_jtag=4'b0101 next cycle. Then en=1, d=0 -> stays 4'b0101. en=0, d=4'b1010 -> stays 4'b0101.
- Good unlock: key_ref=32'hA5A5_5A5A; key_in same, mask=4'b0011, key_valid at cycle N -> key_ack/key_pass=1 at N+2, lock_jtag=4'b1100 at N+3.
- Lockout: three wrong keys (32'h0) -> tries_left 2,1,0. After the third, lockout=1, lock_jtag=4'b1111. A fourth attempt with the correct key gets no ack. rst restores tries_left=3.
- Collision: during RESULT of a good key with mask=4'b1111, drive en=1, d=4'b1000 -> lock_jtag=4'b1000.
- Macro undefined: correct key presented -> no ack, lock_jtag unchanged; only rst changes the lock state.
